// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache controller.
package dm_cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RF   = 2'd2
  } cache_state_e;

  localparam int STATS_W = 32;

  // Extract a bit field from an address: width bits starting at lsb.
  function automatic int unsigned addr_field(input int unsigned addr,
                                             input int          lsb,
                                             input int          width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_line_array.sv
// Line data RAM: one whole line per set, async whole-line read,
// full-line write for refill and single-word write for store hits.
module cache_line_array #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 32,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int IDX_W     = $clog2(SETS),
  localparam int LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic              word_we,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [WORD_W-1:0] word_data,
  input  logic              line_we,
  input  logic [LINE_W-1:0] line_data,
  output logic [LINE_W-1:0] rd_line
);

  logic [LINE_W-1:0] lines_q [SETS];

  assign rd_line = lines_q[idx];

  // Refill replaces the whole line; a store hit touches only its word.
  always_ff @(posedge clk) begin
    if (line_we) begin
      lines_q[idx] <= line_data;
    end else if (word_we) begin
      lines_q[idx][word_off*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back data cache controller.
// Optional build macro CACHE_STATS_EN adds hit/miss/writeback counters.
//
// state | meaning
// IDLE  | serve hits; on a miss choose writeback or refill
// WB    | writing dirty victim line back to memory
// RF    | fetching requested line from memory
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 32,
  parameter int ADDR_W     = 10,
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int IDX_W     = $clog2(SETS),
  localparam int TAG_W     = ADDR_W - IDX_W - OFF_W,
  localparam int LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [WORD_W-1:0]       cpu_wdata,
  output logic [WORD_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [LINE_W-1:0]       mem_wline,
  input  logic [LINE_W-1:0]       mem_rline,
  input  logic                    mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [STATS_W-1:0]      hit_cnt,
  output logic [STATS_W-1:0]      miss_cnt,
  output logic [STATS_W-1:0]      wb_cnt
`endif
);

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic              hit;
  logic              victim_dirty;
  logic              line_we;
  logic              word_we;
  logic [LINE_W-1:0] rd_line;
  cache_state_e      state_q;

  assign req_off = OFF_W'(addr_field(32'(cpu_addr), 0, OFF_W));
  assign req_idx = IDX_W'(addr_field(32'(cpu_addr), OFF_W, IDX_W));
  assign req_tag = TAG_W'(addr_field(32'(cpu_addr), OFF_W + IDX_W, TAG_W));

  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign cpu_ready    = (state_q == ST_IDLE) && cpu_req && hit;
  assign cpu_rdata    = rd_line[req_off*WORD_W +: WORD_W];

  // Array writes are suppressed under reset so an abandoned refill leaves no trace.
  assign word_we = cpu_ready && cpu_we && !rst;
  assign line_we = (state_q == ST_RF) && mem_ack && !rst;

  cache_line_array #(
    .WORD_W    (WORD_W),
    .LINE_WORDS(LINE_WORDS),
    .SETS      (SETS)
  ) u_lines (
    .clk      (clk),
    .idx      (req_idx),
    .word_we  (word_we),
    .word_off (req_off),
    .word_data(cpu_wdata),
    .line_we  (line_we),
    .line_data(mem_rline),
    .rd_line  (rd_line)
  );

  // Tag store is not reset; valid gates its use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[req_idx] <= req_tag;
    end
  end

  // Valid/dirty flags: cleared in one cycle by reset, set by refill and store hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[req_idx] <= 1'b1;
    end
  end

  // Miss FSM with registered memory-side outputs; WB hands straight over to RF.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wline <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req && !hit) begin
            mem_req <= 1'b1;
            if (victim_dirty) begin
              state_q   <= ST_WB;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[req_idx], req_idx};
              mem_wline <= rd_line;
            end else begin
              state_q  <= ST_RF;
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx};
            end
          end
        end
        ST_WB: begin
          if (mem_ack) begin
            state_q  <= ST_RF;
            mem_we   <= 1'b0;
            mem_addr <= {req_tag, req_idx};
          end
        end
        ST_RF: begin
          if (mem_ack) begin
            state_q <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic refill_done_q;

  // Saturating event counters; the hit that completes a miss is not a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      wb_cnt        <= '0;
      refill_done_q <= 1'b0;
    end else begin
      if (line_we) begin
        refill_done_q <= 1'b1;
      end else if (cpu_ready) begin
        refill_done_q <= 1'b0;
      end
      if (cpu_ready && !refill_done_q && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + STATS_W'(1);
      end
      if ((state_q == ST_IDLE) && cpu_req && !hit && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + STATS_W'(1);
      end
      if ((state_q == ST_WB) && mem_ack && (wb_cnt != '1)) begin
        wb_cnt <= wb_cnt + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios then random traffic
// against a word-level memory model and a tag-occupancy model of the cache.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_req;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [127:0] mem_wline;
  logic [127:0] mem_rline;
  logic         mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0]  mem_words [1024];
  logic [31:0]  arch      [1024];
  bit           m_valid   [32];
  bit           m_dirty   [32];
  logic [2:0]   m_tag     [32];
  int           e_hits, e_miss, e_wb;
  logic [127:0] last_t0_line;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wline(mem_wline),
    .mem_rline(mem_rline), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Core protocol: a pending request must be held until it completes.
  logic pend = 1'b0;
  always @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else begin
      if (pend) assert (cpu_req) else begin
        errors++;
        $error("FAIL req_dropped observed=0 expected=1");
      end
      pend <= cpu_req && !cpu_ready;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one access and act as memory until it completes.
  task automatic access(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                        input int d, output int cyc, output int ntx,
                        output logic t0_we, output logic [7:0] t0_addr,
                        output logic [127:0] t0_line, output logic t1_we,
                        output logic [7:0] t1_addr);
    logic         in_txn = 1'b0;
    logic         done = 1'b0;
    int           w = 0;
    logic         cur_we = 1'b0;
    logic [7:0]   cur_addr = '0;
    logic [127:0] cur_line = '0;
    cyc = -1; ntx = 0;
    t0_we = 1'b0; t0_addr = '0; t0_line = '0; t1_we = 1'b0; t1_addr = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (cpu_ready) begin
        done = 1'b1;
        cyc  = i;
        if (!we) chk("load_data", 128'(cpu_rdata), 128'(arch[addr]));
        else arch[addr] = wd;
      end else if (mem_req) begin
        if (!in_txn) begin
          in_txn = 1'b1; w = 0;
          cur_we = mem_we; cur_addr = mem_addr; cur_line = mem_wline;
          if (ntx == 0) begin t0_we = mem_we; t0_addr = mem_addr; t0_line = mem_wline; end
          else begin t1_we = mem_we; t1_addr = mem_addr; end
          ntx++;
        end else begin
          chk("mem_stable", {mem_we, mem_addr, cur_we ? mem_wline : 128'd0},
                            {cur_we, cur_addr, cur_we ? cur_line : 128'd0});
        end
        if (w == d) begin
          mem_ack = 1'b1;
          for (int k = 0; k < 4; k++) begin
            mem_rline[k*32 +: 32] = mem_words[{mem_addr, 2'(k)}];
            if (mem_we) mem_words[{mem_addr, 2'(k)}] = mem_wline[k*32 +: 32];
          end
          in_txn = 1'b0;
        end else w++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    if (!done) chk("timeout", 128'd0, 128'd1);
    cpu_req = 1'b0;
  endtask

  // Predict the outcome from the model, run the access, check, update the model.
  task automatic do_op(input logic we, input logic [9:0] addr, input logic [31:0] wd, input int d);
    logic [4:0]   idx = addr[6:2];
    logic [2:0]   tg  = addr[9:7];
    bit           e_hit, e_dwb;
    logic [127:0] vline;
    int cyc, ntx;
    logic t0_we, t1_we;
    logic [7:0] t0_addr, t1_addr;
    logic [127:0] t0_line;
    e_hit = m_valid[idx] && (m_tag[idx] == tg);
    e_dwb = !e_hit && m_valid[idx] && m_dirty[idx];
    for (int k = 0; k < 4; k++) vline[k*32 +: 32] = arch[{m_tag[idx], idx, 2'(k)}];
    access(we, addr, wd, d, cyc, ntx, t0_we, t0_addr, t0_line, t1_we, t1_addr);
    last_t0_line = t0_line;
    if (e_hit) begin
      chk("hit_cycles", 128'(cyc), 128'd0);
      chk("hit_no_mem", 128'(ntx), 128'd0);
      e_hits++;
    end else if (e_dwb) begin
      chk("dmiss_cycles", 128'(cyc), 128'(3 + 2*d));
      chk("dmiss_ntx", 128'(ntx), 128'd2);
      chk("wb_we", 128'(t0_we), 128'd1);
      chk("wb_addr", 128'(t0_addr), 128'({m_tag[idx], idx}));
      chk("wb_line", t0_line, vline);
      chk("rf_we", 128'(t1_we), 128'd0);
      chk("rf_addr", 128'(t1_addr), 128'(addr[9:2]));
      e_miss++; e_wb++;
    end else begin
      chk("cmiss_cycles", 128'(cyc), 128'(2 + d));
      chk("cmiss_ntx", 128'(ntx), 128'd1);
      chk("rf_we", 128'(t0_we), 128'd0);
      chk("rf_addr", 128'(t0_addr), 128'(addr[9:2]));
      e_miss++;
    end
    if (!e_hit) begin m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0; end
    if (we) m_dirty[idx] = 1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 32; s++) begin m_valid[s] = 0; m_dirty[s] = 0; m_tag[s] = '0; end
    for (int a = 0; a < 1024; a++) arch[a] = mem_words[a];
    e_hits = 0; e_miss = 0; e_wb = 0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hits"}, 128'(hit_cnt), 128'(e_hits));
    chk({tag, "_miss"}, 128'(miss_cnt), 128'(e_miss));
    chk({tag, "_wb"}, 128'(wb_cnt), 128'(e_wb));
`else
    chk({tag, "_idle"}, 128'(mem_req), 128'd0);
`endif
  endtask

  initial begin
    logic [9:0] ra;
    bit seen;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rline = '0;
    for (int a = 0; a < 1024; a++) mem_words[a] = $urandom;
    mem_words[0] = 32'h1111_000A; mem_words[1] = 32'h2222_000B;
    mem_words[2] = 32'h3333_000C; mem_words[3] = 32'h4444_000D;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 128'(cpu_ready), 128'd0);
    chk("rst_mem_req", 128'(mem_req), 128'd0);
    chk("rst_mem_we", 128'(mem_we), 128'd0);
`ifdef CACHE_STATS_EN
    chk("rst_hit_cnt", 128'(hit_cnt), 128'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    do_op(1'b0, 10'h000, 32'h0, 0);
    do_op(1'b1, 10'h003, 32'hDEAD_BEEF, 0);
    do_op(1'b0, 10'h003, 32'h0, 0);
    do_op(1'b0, 10'h083, 32'h0, 0);
    chk("wb_word3", 128'(last_t0_line[127:96]), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    chk_stats("t123");
`ifdef CACHE_STATS_EN
    chk("t6_hits", 128'(hit_cnt), 128'd2);
    chk("t6_miss", 128'(miss_cnt), 128'd2);
    chk("t6_wb", 128'(wb_cnt), 128'd1);
`endif

    do_op(1'b0, 10'h100, 32'h0, 5);

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h204;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (mem_req) seen = 1;
      else @(negedge clk);
    end
    chk("t5_rf_seen", 128'(seen), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_req_drop", 128'(mem_req), 128'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_stats("after_rst");
    @(negedge clk);
    do_op(1'b0, 10'h000, 32'h0, 0);

    for (int n = 0; n < 200; n++) begin
      ra = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_op(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 3));
    end
    chk_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
